// File: rtl/core_mem_bridge.sv
// core_mem_bridge
//
// Responder for the core's word-granular memory interface. Each mem_start
// pulse is latched and run as one Avalon-MM pipelined master transaction.
// Completion is reported as a one-cycle mem_ready pulse.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   mem_addr[29:0]      word address, sampled with mem_start
//   mem_data_wr[31:0]   store data, sampled with mem_start
//   mem_start           one-cycle request pulse
//   mem_write           1 = store, 0 = load, sampled with mem_start
//   mem_ready           one-cycle completion pulse
//   mem_data_rd[31:0]   load data; held until the next read completion
//   avl_*               Avalon-MM master (address, read, write, writedata,
//                       byteenable, waitrequest, readdata, readdatavalid)
//   busy                high while a transaction is outstanding
//   fault               sticky: timeout abort or mem_start while busy
//
// Avalon handshake: a command (avl_read/avl_write with address and data) is
// presented and held unchanged while avl_waitrequest=1; it is accepted on the
// first rising edge that sees avl_waitrequest=0 and dropped after that edge.
// Read data is taken on the rising edge that sees avl_readdatavalid=1 while
// waiting for it; readdatavalid at any other time is ignored.

module core_mem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] FAULT_DATA     = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_data_wr,
  input  logic        mem_start,
  input  logic        mem_write,
  output logic        mem_ready,
  output logic [31:0] mem_data_rd,
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid,
  output logic        busy,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    READ_WAIT = 2'd2
  } state_t;

  // Counter value seen on the edge where the limit is reached. Unused when
  // TIMEOUT_CYCLES is 0 (the timeout term below is then constant false).
  localparam logic [31:0] TLIM = TIMEOUT_CYCLES - 32'd1;

  state_t      state;
  state_t      state_nxt;
  logic        is_write;
  logic [31:0] tcount;
  logic        accept;
  logic        rdone;
  logic        tout;

  assign avl_byteenable = 4'b1111;

  // Normal completion takes priority over a timeout on the same edge.
  always_comb begin
    accept = (state == ISSUE) && !avl_waitrequest;
    rdone  = (state == READ_WAIT) && avl_readdatavalid;
    tout   = (TIMEOUT_CYCLES != 0) && (state != IDLE) && !accept && !rdone &&
             (tcount == TLIM);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (mem_start) state_nxt = ISSUE;
      ISSUE:     if (accept) state_nxt = is_write ? IDLE : READ_WAIT;
                 else if (tout) state_nxt = IDLE;
      READ_WAIT: if (rdone || tout) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready     <= 1'b0;
      mem_data_rd   <= 32'd0;
      avl_address   <= 32'd0;
      avl_read      <= 1'b0;
      avl_write     <= 1'b0;
      avl_writedata <= 32'd0;
      is_write      <= 1'b0;
      tcount        <= 32'd0;
      busy          <= 1'b0;
      fault         <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      busy      <= (state_nxt != IDLE);
      if (state != IDLE) tcount <= tcount + 32'd1;

      case (state)
        IDLE: begin
          if (mem_start) begin
            avl_address   <= {mem_addr, 2'b00};
            avl_writedata <= mem_data_wr;
            is_write      <= mem_write;
            avl_read      <= ~mem_write;
            avl_write     <= mem_write;
            tcount        <= 32'd0;
          end
        end
        ISSUE: begin
          if (accept) begin
            avl_read  <= 1'b0;
            avl_write <= 1'b0;
            tcount    <= 32'd0;
            if (is_write) mem_ready <= 1'b1;
          end else if (tout) begin
            avl_read  <= 1'b0;
            avl_write <= 1'b0;
            mem_ready <= 1'b1;
            fault     <= 1'b1;
            if (!is_write) mem_data_rd <= FAULT_DATA;
          end
        end
        READ_WAIT: begin
          if (rdone) begin
            mem_data_rd <= avl_readdata;
            mem_ready   <= 1'b1;
          end else if (tout) begin
            mem_data_rd <= FAULT_DATA;
            mem_ready   <= 1'b1;
            fault       <= 1'b1;
          end
        end
        default: ;
      endcase

      // A request arriving while busy is dropped; the running one continues.
      if (mem_start && (state != IDLE)) fault <= 1'b1;
    end
  end

endmodule
